uncache_bus_master: RTL and testbench

Bus master for uncached CPU loads and stores, sitting directly upstream of the bus arbiter on its uncache port. It accepts one request at a time from the memory stage and raises `uncache_bus_req`. It waits for `bus_uncache_grant`, runs a burst of 1..MAX_BURST single-word beats on the shared bus, and then pulses `uncache_bus_free` so the arbiter returns to idle. Read data is returned to the memory stage word by word, and completion is signalled once per request.

---
 rtl/uncache_bus_master.sv | 152 +++++++++++++++
 tb/tb_uncache_bus_master.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uncache_bus_master.sv
// Purpose: uncached load/store bus master; one request at a time, 1..MAX_BURST word beats.
// Latency: req_ready->uncache_bus_req 1 cycle; first beat 1 cycle after grant is sampled; done 1 cycle after last ack.
// Backpressure: req_ready low while busy; beats stall while grant is low or bus_ack is withheld.
//
// Ports:
//   clk, resetn          clock, synchronous reset (1 = reset)
//   req_*                CPU request (valid/ready, we, addr, wdata, words)
//   resp_valid/rdata     registered per-beat read return
//   done                 one-cycle completion pulse per request
//   uncache_bus_req/free request / release towards the arbiter
//   bus_uncache_grant    grant from the arbiter
//   bus_valid/we/addr/wdata, bus_ack/rdata   shared-bus beat interface
module uncache_bus_master #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 3
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [CNT_W-1:0]  req_words,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              done,
  output logic              uncache_bus_req,
  input  logic              bus_uncache_grant,
  output logic              uncache_bus_free,
  output logic              bus_valid,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_XFER,
    S_FREE
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] base_q, base_nxt;
  logic [CNT_W-1:0]  cnt_q, cnt_nxt;
  logic [CNT_W-1:0]  idx_q, idx_nxt;
  logic              we_nxt;
  logic [DATA_W-1:0] wdata_nxt;
  logic [CNT_W-1:0]  words_norm;
  logic [ADDR_W-1:0] addr_nxt;
  logic              beat_done;

  // A zero count still moves one word; oversize counts saturate at the burst limit.
  always_comb begin
    words_norm = req_words;
    if (req_words == '0) begin
      words_norm = ONE;
    end else if (req_words > MAX_CNT) begin
      words_norm = MAX_CNT;
    end
  end

  assign req_ready = (state == S_IDLE);
  // Grant loss mid-burst only pauses the beat; the index is kept.
  assign bus_valid = (state == S_XFER) && bus_uncache_grant;
  assign beat_done = bus_valid && bus_ack;

  always_comb begin
    state_nxt = state;
    base_nxt  = base_q;
    cnt_nxt   = cnt_q;
    idx_nxt   = idx_q;
    we_nxt    = bus_we;
    wdata_nxt = bus_wdata;
    unique case (state)
      S_IDLE: begin
        if (req_valid) begin
          state_nxt = S_REQ;
          base_nxt  = req_addr & ~ADDR_W'(3);
          cnt_nxt   = words_norm;
          idx_nxt   = '0;
          we_nxt    = req_we;
          wdata_nxt = req_wdata;
        end
      end
      S_REQ: begin
        if (bus_uncache_grant) begin
          state_nxt = S_XFER;
        end
      end
      S_XFER: begin
        if (beat_done) begin
          idx_nxt = idx_q + ONE;
          if (idx_q == cnt_q - ONE) begin
            state_nxt = S_FREE;
          end
        end
      end
      S_FREE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Beat address is precomputed from the next index so bus_addr can be a flop;
  // the add wraps naturally at the top of the address space.
  assign addr_nxt = base_nxt + {{(ADDR_W-CNT_W-2){1'b0}}, idx_nxt, 2'b00};

  always_ff @(posedge clk) begin
    if (resetn) begin
      state            <= S_IDLE;
      base_q           <= '0;
      cnt_q            <= '0;
      idx_q            <= '0;
      bus_we           <= 1'b0;
      bus_wdata        <= '0;
      bus_addr         <= '0;
      uncache_bus_req  <= 1'b0;
      uncache_bus_free <= 1'b0;
      done             <= 1'b0;
      resp_valid       <= 1'b0;
      resp_rdata       <= '0;
    end else begin
      state            <= state_nxt;
      base_q           <= base_nxt;
      cnt_q            <= cnt_nxt;
      idx_q            <= idx_nxt;
      bus_we           <= we_nxt;
      bus_wdata        <= wdata_nxt;
      bus_addr         <= addr_nxt;
      uncache_bus_req  <= (state_nxt == S_REQ);
      uncache_bus_free <= (state_nxt == S_FREE);
      done             <= (state_nxt == S_FREE);
      resp_valid       <= beat_done && !bus_we;
      if (beat_done && !bus_we) begin
        resp_rdata <= bus_rdata;
      end
    end
  end

endmodule

// File: tb/tb_uncache_bus_master.sv
// Purpose: directed bench for uncache_bus_master with a cycle-stepped arbiter and slave model.
// Latency: n/a (testbench).
// Backpressure: grant delay and ack spacing come from each vector.
module tb_uncache_bus_master;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_words;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        done;
  logic        uncache_bus_req;
  logic        bus_uncache_grant;
  logic        uncache_bus_free;
  logic        bus_valid;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  always #5 clk = ~clk;

  uncache_bus_master dut (
    .clk              (clk),
    .resetn           (resetn),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_we           (req_we),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .req_words        (req_words),
    .resp_valid       (resp_valid),
    .resp_rdata       (resp_rdata),
    .done             (done),
    .uncache_bus_req  (uncache_bus_req),
    .bus_uncache_grant(bus_uncache_grant),
    .uncache_bus_free (uncache_bus_free),
    .bus_valid        (bus_valid),
    .bus_we           (bus_we),
    .bus_addr         (bus_addr),
    .bus_wdata        (bus_wdata),
    .bus_ack          (bus_ack),
    .bus_rdata        (bus_rdata)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  words;
    logic [7:0]  gnt_dly;
    logic [7:0]  ack_gap;
    logic [31:0] rdata;
    logic [2:0]  exp_beats;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [31:0] a2;
    logic [31:0] a3;
  } vec_t;

  vec_t tbl [7];
  int   total = 0;
  int   bad   = 0;
  int   req_cnt;
  logic free_last;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [2:0] words, input logic [7:0] dly, input logic [7:0] gap,
                              input logic [31:0] rdata, input logic [2:0] nb,
                              input logic [31:0] a0, input logic [31:0] a1,
                              input logic [31:0] a2, input logic [31:0] a3);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.words = words;
    v.gnt_dly = dly; v.ack_gap = gap; v.rdata = rdata; v.exp_beats = nb;
    v.a0 = a0; v.a1 = a1; v.a2 = a2; v.a3 = a3;
    return v;
  endfunction

  function automatic logic [31:0] exp_addr(input vec_t v, input int i);
    case (i)
      0:       return v.a0;
      1:       return v.a1;
      2:       return v.a2;
      3:       return v.a3;
      default: return 32'hxxxx_xxxx;
    endcase
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_bus_req"},    uncache_bus_req, 0);
    chk({tag, "_free"},       uncache_bus_free, 0);
    chk({tag, "_bus_valid"},  bus_valid, 0);
    chk({tag, "_bus_we"},     bus_we, 0);
    chk({tag, "_bus_addr"},   bus_addr, 0);
    chk({tag, "_bus_wdata"},  bus_wdata, 0);
    chk({tag, "_resp_valid"}, resp_valid, 0);
    chk({tag, "_resp_rdata"}, resp_rdata, 0);
    chk({tag, "_done"},       done, 0);
    chk({tag, "_req_ready"},  req_ready, 1);
  endtask

  // Runs one request from acceptance to the IDLE cycle after FREE.
  // hold keeps req_valid high throughout; rst_at>0 pulses reset after that many acks.
  task automatic run(input vec_t v, input bit hold, input int rst_at);
    int          beats     = 0;
    int          vcnt      = 0;
    int          g_cyc     = 0;
    bit          done_seen = 0;
    bit          prev_ack  = 0;
    bit          prev_last = 0;
    bit          cur_ack;
    logic [31:0] prev_data = '0;

    chk("accept_ready", req_ready, 1);
    req_valid = 1'b1;
    req_we    = v.we;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    req_words = v.words;

    for (int c = 1; c <= 200 && !done_seen; c++) begin
      @(negedge clk);
      if (!hold) req_valid = 1'b0;
      req_we    = ~v.we;
      req_addr  = $urandom;
      req_wdata = $urandom;
      req_words = 3'($urandom_range(0, 7));

      // Arbiter: grants after seeing req for gnt_dly+1 cycles, drops one cycle after free.
      if (bus_uncache_grant && free_last) begin
        bus_uncache_grant = 1'b0;
        req_cnt = 0;
      end else if (!bus_uncache_grant && req_cnt > int'(v.gnt_dly)) begin
        bus_uncache_grant = 1'b1;
        g_cyc = c;
      end
      #1;
      // Slave: acks every (ack_gap+1)th valid cycle; stray acks when not valid must be ignored.
      bus_rdata = v.rdata + 32'(beats);
      if (bus_valid) begin
        bus_ack = (vcnt == int'(v.ack_gap));
        vcnt    = bus_ack ? 0 : vcnt + 1;
      end else begin
        bus_ack = c[0];
      end
      #1;

      chk("busy_ready", req_ready, 0);
      chk("bus_req", uncache_bus_req, (g_cyc == 0 || c == g_cyc));
      if (!bus_uncache_grant) chk("valid_without_grant", bus_valid, 0);
      if (g_cyc != 0 && c == g_cyc + 1) chk("first_beat_after_grant", bus_valid, 1);
      chk("resp_valid", resp_valid, prev_ack && !v.we);
      if (prev_ack && !v.we) chk("resp_rdata", resp_rdata, prev_data);
      chk("done", done, prev_last);
      chk("free", uncache_bus_free, prev_last);
      if (done) done_seen = 1;

      cur_ack = bus_valid && bus_ack;
      if (cur_ack) begin
        chk("beat_addr", bus_addr, exp_addr(v, beats));
        chk("beat_we", bus_we, v.we);
        if (v.we) chk("beat_wdata", bus_wdata, v.wdata);
        prev_data = bus_rdata;
        beats++;
      end
      prev_ack  = cur_ack;
      prev_last = cur_ack && (beats == int'(v.exp_beats));
      if (uncache_bus_req) req_cnt++;
      free_last = uncache_bus_free;

      if (rst_at != 0 && cur_ack && beats == rst_at) begin
        resetn = 1'b1;
        @(negedge clk);
        #2;
        chk_all_zero("midrst");
        resetn            = 1'b0;
        bus_uncache_grant = 1'b0;
        bus_ack           = 1'b0;
        req_cnt           = 0;
        free_last         = 1'b0;
        return;
      end
    end

    chk("done_seen", done_seen, 1);
    chk("beat_count", beats, 32'(v.exp_beats));

    @(negedge clk);
    if (bus_uncache_grant && free_last) begin
      bus_uncache_grant = 1'b0;
      req_cnt = 0;
    end
    bus_ack   = 1'b0;
    free_last = 1'b0;
    #2;
    chk("idle_ready", req_ready, 1);
    chk("idle_bus_req", uncache_bus_req, 0);
    chk("idle_done", done, 0);
    chk("idle_free", uncache_bus_free, 0);
  endtask

  initial begin
    resetn            = 1'b1;
    req_valid         = 1'b0;
    req_we            = 1'b0;
    req_addr          = '0;
    req_wdata         = '0;
    req_words         = '0;
    bus_uncache_grant = 1'b0;
    bus_ack           = 1'b0;
    bus_rdata         = '0;
    req_cnt           = 0;
    free_last         = 1'b0;

    //            we    addr           wdata          wrds dly  gap  rdata          nb  beat addresses
    tbl[0] = mk(1'b0, 32'h1000_0004, 32'h0,          3'd1, 8'd0, 8'd0, 32'hDEAD_BEEF, 3'd1,
                32'h1000_0004, 32'h0, 32'h0, 32'h0);
    tbl[1] = mk(1'b1, 32'h2000_0000, 32'hA5A5_A5A5, 3'd4, 8'd0, 8'd1, 32'h0,         3'd4,
                32'h2000_0000, 32'h2000_0004, 32'h2000_0008, 32'h2000_000C);
    tbl[2] = mk(1'b0, 32'h3000_0010, 32'h0,          3'd2, 8'd10, 8'd0, 32'h1111_0000, 3'd2,
                32'h3000_0010, 32'h3000_0014, 32'h0, 32'h0);
    tbl[3] = mk(1'b1, 32'h4000_0008, 32'h1234_5678, 3'd0, 8'd0, 8'd0, 32'h0,         3'd1,
                32'h4000_0008, 32'h0, 32'h0, 32'h0);
    tbl[4] = mk(1'b0, 32'h5000_0000, 32'h0,          3'd7, 8'd1, 8'd2, 32'h2222_0000, 3'd4,
                32'h5000_0000, 32'h5000_0004, 32'h5000_0008, 32'h5000_000C);
    tbl[5] = mk(1'b0, 32'hFFFF_FFFC, 32'h0,          3'd2, 8'd0, 8'd0, 32'h3333_0000, 3'd2,
                32'hFFFF_FFFC, 32'h0000_0000, 32'h0, 32'h0);
    tbl[6] = mk(1'b1, 32'h0000_0103, 32'hCAFE_F00D, 3'd1, 8'd0, 8'd0, 32'h0,         3'd1,
                32'h0000_0100, 32'h0, 32'h0, 32'h0);

    repeat (3) @(negedge clk);
    #2;
    chk_all_zero("rst");
    resetn = 1'b0;
    @(negedge clk);
    #2;
    chk("ready_after_rst", req_ready, 1);

    for (int i = 0; i < 7; i++) run(tbl[i], 1'b0, 0);

    // Reset after the 2nd of 4 load acks, then a normal request.
    run(mk(1'b0, 32'h6000_0000, 32'h0, 3'd4, 8'd0, 8'd0, 32'h7700_0000, 3'd4,
           32'h6000_0000, 32'h6000_0004, 32'h6000_0008, 32'h6000_000C), 1'b0, 2);
    run(tbl[0], 1'b0, 0);

    // Back-to-back loads with req_valid held high across the first one.
    run(mk(1'b0, 32'h7000_0000, 32'h0, 3'd2, 8'd0, 8'd0, 32'h8000_0000, 3'd2,
           32'h7000_0000, 32'h7000_0004, 32'h0, 32'h0), 1'b1, 0);
    run(mk(1'b0, 32'h7100_0040, 32'h0, 3'd1, 8'd0, 8'd0, 32'h9000_0000, 3'd1,
           32'h7100_0040, 32'h0, 32'h0, 32'h0), 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
